// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_pkg
// Brief    : Shared constants, pointer types and full-detect helper for the
//            single-clock FIFO. Optional read mode macro: FIFO_FWFT_EN.
// Revision : 1.0
// ============================================================================
package sync_fifo_pkg;

    localparam int C_DEFAULT_DEPTH      = 256;
    localparam int C_DEFAULT_DATA_WIDTH = 8;
    localparam int C_DEFAULT_ADDR_WIDTH = $clog2(C_DEFAULT_DEPTH);

    // Pointer type for the default configuration; other depths carry their
    // pointers zero-extended in ptr_wide_t when calling is_full().
    typedef logic [C_DEFAULT_ADDR_WIDTH:0] ptr_t;
    typedef logic [31:0]                   ptr_wide_t;

    function automatic logic is_full(
        input ptr_wide_t wr_ptr,
        input ptr_wide_t rd_ptr,
        input int        addr_width
    );
        ptr_wide_t w_diff;
        ptr_wide_t w_mask;
        w_diff = wr_ptr ^ rd_ptr;
        w_mask = (ptr_wide_t'(1) << addr_width) - ptr_wide_t'(1);
        return (w_diff[addr_width] == 1'b1) && ((w_diff & w_mask) == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl_if
// Brief    : Producer/consumer bus of the single-clock FIFO. The master side
//            is the user logic, the slave side is the FIFO itself.
// Revision : 1.0
// ============================================================================
interface sync_fifo_ctrl_if
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = C_DEFAULT_DEPTH,
    parameter int DATA_WIDTH = C_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) ();

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   af_thresh;
    logic [ADDR_WIDTH:0]   ae_thresh;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;
    logic                  err_clr;

    modport master (
        output wr_en, data_in, rd_en, af_thresh, ae_thresh, err_clr,
        input  data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en, af_thresh, ae_thresh, err_clr,
        output data_out, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

endinterface
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ram
// Brief    : Simple dual-port RAM. Registered read port by default,
//            asynchronous read when FIFO_FWFT_EN is defined.
// Revision : 1.0
// ============================================================================
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = C_DEFAULT_DEPTH,
    parameter int DATA_WIDTH = C_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  i_wr_en,
    input  wire logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wr_data,
`ifndef FIFO_FWFT_EN
    input  wire logic                  i_rd_en,
`endif
    input  wire logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic      [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

`ifdef FIFO_FWFT_EN
    assign o_rd_data = r_mem[i_rd_addr];
`else
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_ctrl
// Brief    : Single-clock FIFO controller: pointers, occupancy count, status
//            flags and sticky error flags around sync_fifo_ram.
//            Define FIFO_FWFT_EN for first-word-fall-through reads.
// Revision : 1.0
// ============================================================================
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int DEPTH      = C_DEFAULT_DEPTH,
    parameter int DATA_WIDTH = C_DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input wire logic        clk,
    input wire logic        rst,
    sync_fifo_ctrl_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] c_ptr_one = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [DATA_WIDTH-1:0] w_ram_rd_data;

    // Pointer-based full always coincides with r_count == DEPTH.
    assign w_full   = is_full(ptr_wide_t'(r_wr_ptr), ptr_wide_t'(r_rd_ptr), ADDR_WIDTH);
    assign w_empty  = (r_count == '0);
    assign w_rd_acc = bus.rd_en & ~w_empty;
    assign w_wr_acc = bus.wr_en & (~w_full | w_rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end

            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_ptr_one;
                2'b01:   r_count <= r_count - c_ptr_one;
                default: r_count <= r_count;
            endcase

            // A new error in the same cycle as err_clr keeps the flag set.
            if (bus.wr_en & ~w_wr_acc) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end

            if (bus.rd_en & ~w_rd_acc) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    sync_fifo_ram #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_acc),
        .i_wr_addr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wr_data (bus.data_in),
`ifndef FIFO_FWFT_EN
        .i_rd_en   (w_rd_acc),
`endif
        .i_rd_addr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rd_data (w_ram_rd_data)
    );

`ifdef FIFO_FWFT_EN
    assign bus.data_out = w_ram_rd_data;
    assign bus.rd_valid = ~w_empty;
`else
    logic r_rd_valid;
    logic r_data_loaded;

    // The RAM read register is never reset, so data_out is forced to zero
    // until the first read after reset has loaded it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid    <= 1'b0;
            r_data_loaded <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_loaded <= 1'b1;
            end
        end
    end

    assign bus.data_out = r_data_loaded ? w_ram_rd_data : '0;
    assign bus.rd_valid = r_rd_valid;
`endif

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.almost_full  = (r_count >= bus.af_thresh);
    assign bus.almost_empty = (r_count <= bus.ae_thresh);
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_ctrl
// Brief    : Self-checking bench for sync_fifo_ctrl (DEPTH=8) with a queue
//            reference model and a read-data scoreboard. Honours FIFO_FWFT_EN.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sync_fifo_ctrl_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

    sync_fifo_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    bit            m_ovf;
    bit            m_unf;
    bit            m_rd_acc_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        int sz;
        sz = model_q.size();
        chk("count",        32'(bus.count),        32'(sz));
        chk("full",         32'(bus.full),         32'(sz == DEPTH));
        chk("empty",        32'(bus.empty),        32'(sz == 0));
        chk("almost_full",  32'(bus.almost_full),  32'(sz >= int'(bus.af_thresh)));
        chk("almost_empty", 32'(bus.almost_empty), 32'(sz <= int'(bus.ae_thresh)));
        chk("overflow",     32'(bus.overflow),     32'(m_ovf));
        chk("underflow",    32'(bus.underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
        chk("rd_valid",     32'(bus.rd_valid),     32'(sz > 0));
`else
        chk("rd_valid",     32'(bus.rd_valid),     32'(m_rd_acc_d));
`endif
    endtask

    // Drive one cycle, advance the reference model, then check after the edge.
    task automatic step(input bit wr, input logic [DW-1:0] d, input bit rd,
                        input bit clr, input bit rs);
        bit racc;
        bit wacc;
        rst         = rs;
        bus.wr_en   = wr;
        bus.data_in = d;
        bus.rd_en   = rd;
        bus.err_clr = clr;
        if (rs) begin
            model_q.delete();
            m_ovf      = 1'b0;
            m_unf      = 1'b0;
            m_rd_acc_d = 1'b0;
        end else begin
            racc = rd && (model_q.size() > 0);
            wacc = wr && ((model_q.size() < DEPTH) || racc);
            if (racc) exp_q.push_back(model_q.pop_front());
            if (wacc) model_q.push_back(d);
            if (wr && !wacc) m_ovf = 1'b1;
            else if (clr)    m_ovf = 1'b0;
            if (rd && !racc) m_unf = 1'b1;
            else if (clr)    m_unf = 1'b0;
            m_rd_acc_d = racc;
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    // Scoreboard monitor: every presented read word must match the oldest expectation.
    always @(negedge clk) begin
        logic [DW-1:0] e;
`ifdef FIFO_FWFT_EN
        if (bus.rd_valid === 1'b1 && bus.rd_en === 1'b1 && rst === 1'b0) begin
`else
        if (bus.rd_valid === 1'b1) begin
`endif
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_read actual=%0h required=none t=%0t", bus.data_out, $time);
            end else begin
                e = exp_q.pop_front();
                chk("read_data", 32'(bus.data_out), 32'(e));
            end
        end
    end

    initial begin
        bus.wr_en     = 1'b0;
        bus.data_in   = '0;
        bus.rd_en     = 1'b0;
        bus.err_clr   = 1'b0;
        bus.af_thresh = 4'd6;
        bus.ae_thresh = 4'd2;

        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 0, 0, 1);
`ifndef FIFO_FWFT_EN
        chk("reset_data_out", 32'(bus.data_out), 32'h0);
`endif
        chk("reset_empty", 32'(bus.empty), 32'h1);

        // In-order write then read of 0x01..0x05
        for (int i = 1; i <= 5; i++) step(1, 8'(i), 0, 0, 0);
        chk("count_five", 32'(bus.count), 32'd5);
        for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("empty_again", 32'(bus.empty), 32'h1);

        // Fill, overflow, clear, and set-wins-over-clear
        for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h10 + i), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        chk("overflow_set", 32'(bus.overflow), 32'h1);
        chk("full_count", 32'(bus.count), 32'd8);
        step(0, 8'h00, 0, 1, 0);
        chk("overflow_clr", 32'(bus.overflow), 32'h0);
        step(1, 8'hEF, 0, 1, 0);
        chk("overflow_set_wins", 32'(bus.overflow), 32'h1);
        step(0, 8'h00, 0, 1, 0);

        // Full with simultaneous read/write across pointer wrap
        for (int i = 0; i < 20; i++) step(1, 8'(8'h40 + i), 1, 0, 0);
        chk("full_rw_count", 32'(bus.count), 32'd8);
        chk("full_rw_no_ovf", 32'(bus.overflow), 32'h0);
        for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);

        // Empty with simultaneous read/write
        step(1, 8'hA5, 1, 0, 0);
        chk("underflow_set", 32'(bus.underflow), 32'h1);
        chk("empty_rw_count", 32'(bus.count), 32'd1);
        step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 1, 0);

        // Threshold flags during fill, then mid-fill reset
        bus.af_thresh = 4'd6;
        bus.ae_thresh = 4'd2;
        for (int i = 0; i < 6; i++) begin
            step(1, 8'(8'h70 + i), 0, 0, 0);
            if (i == 2) chk("ae_deassert_at_3", 32'(bus.almost_empty), 32'h0);
            if (i == 5) chk("af_assert_at_6", 32'(bus.almost_full), 32'h1);
        end
        step(0, 8'h00, 0, 0, 1);
        chk("mid_reset_count", 32'(bus.count), 32'd0);
        chk("mid_reset_ae", 32'(bus.almost_empty), 32'h1);
        chk("mid_reset_af", 32'(bus.almost_full), 32'h0);

`ifdef FIFO_FWFT_EN
        step(1, 8'h3C, 0, 0, 0);
        chk("fwft_valid", 32'(bus.rd_valid), 32'h1);
        chk("fwft_data", 32'(bus.data_out), 32'h3C);
        step(0, 8'h00, 1, 0, 0);
        chk("fwft_valid_drop", 32'(bus.rd_valid), 32'h0);
`endif

        // Randomised traffic with write-heavy and read-heavy phases
        for (int i = 0; i < 800; i++) begin
            bit rs;
            bit wr;
            bit rd;
            rs = ($urandom % 64) == 0;
            if ((i / 50) % 2 == 0) begin
                wr = ($urandom % 4) != 0;
                rd = ($urandom % 4) == 0;
            end else begin
                wr = ($urandom % 4) == 0;
                rd = ($urandom % 4) != 0;
            end
            if (rs) rd = 1'b0;
            if (($urandom % 16) == 0) bus.af_thresh = 4'($urandom_range(0, 15));
            if (($urandom % 16) == 0) bus.ae_thresh = 4'($urandom_range(0, 15));
            step(wr, 8'($urandom), rd, ($urandom % 8) == 0, rs);
        end

        for (int i = 0; i < DEPTH + 2; i++) step(0, 8'h00, 1, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        step(0, 8'h00, 0, 0, 0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
